// File: rtl/bank_scheduler.sv
// rtl/bank_scheduler.sv - two-requester, four-bank read scheduler with conflict arbitration
// Each requester has one response slot; a stalled slot parks its data in a hold register.
module bank_scheduler #(
  parameter int ARB_MODE = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_req_valid,
  output logic             a_req_ready,
  input  logic [1:0]       a_req_bank,
  input  logic [13:0]      a_req_addr,
  output logic             a_rsp_valid,
  input  logic             a_rsp_ready,
  output logic [31:0]      a_rsp_data,
  input  logic             b_req_valid,
  output logic             b_req_ready,
  input  logic [1:0]       b_req_bank,
  input  logic [13:0]      b_req_addr,
  output logic             b_rsp_valid,
  input  logic             b_rsp_ready,
  output logic [31:0]      b_rsp_data,
  output logic [13:0]      port0_addr,
  output logic [13:0]      port1_addr,
  output logic [13:0]      port2_addr,
  output logic [13:0]      port3_addr,
  input  logic [31:0]      port0_din,
  input  logic [31:0]      port1_din,
  input  logic [31:0]      port2_din,
  input  logic [31:0]      port3_din,
  output logic [CNT_W-1:0] conflict_count
);

  logic             rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [1:0]       live_q, live_d;
  logic [1:0]       bank_q [2];
  logic [1:0]       bank_d [2];
  logic [31:0]      hold_q [2];
  logic [31:0]      hold_d [2];

  logic        a_elig, b_elig, conflict, a_grant, b_grant;
  logic [1:0]  grant, rsp_ready;
  logic [1:0]  req_bank [2];
  logic [31:0] port_din [4];
  logic [13:0] port_addr [4];
  logic [31:0] live_data [2];
  logic [31:0] rsp_data [2];

  // Requests are only considered out of reset, so ready and port addresses stay low while reset is held.
  assign a_elig   = reset & a_req_valid & ~(rsp_valid_q[0] & ~a_rsp_ready);
  assign b_elig   = reset & b_req_valid & ~(rsp_valid_q[1] & ~b_rsp_ready);
  assign conflict = a_elig & b_elig & (a_req_bank == b_req_bank);
  assign a_grant  = a_elig & (~conflict | (ARB_MODE != 0) | ~rr_q);
  assign b_grant  = b_elig & (~conflict | ((ARB_MODE == 0) & rr_q));

  assign a_req_ready = a_grant;
  assign b_req_ready = b_grant;
  assign grant       = {b_grant, a_grant};
  assign rsp_ready   = {b_rsp_ready, a_rsp_ready};
  assign req_bank[0] = a_req_bank;
  assign req_bank[1] = b_req_bank;
  assign port_din[0] = port0_din;
  assign port_din[1] = port1_din;
  assign port_din[2] = port2_din;
  assign port_din[3] = port3_din;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      port_addr[n] = 14'h0000;
      if (a_grant && a_req_bank == 2'(n)) port_addr[n] = a_req_addr;
      if (b_grant && b_req_bank == 2'(n)) port_addr[n] = b_req_addr;
    end
  end

  assign port0_addr = port_addr[0];
  assign port1_addr = port_addr[1];
  assign port2_addr = port_addr[2];
  assign port3_addr = port_addr[3];

  // live_q: the bank is presenting this slot's data right now; otherwise it comes from the hold register.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      live_data[r]   = port_din[bank_q[r]];
      rsp_data[r]    = live_q[r] ? live_data[r] : hold_q[r];
      rsp_valid_d[r] = rsp_valid_q[r];
      live_d[r]      = live_q[r];
      bank_d[r]      = bank_q[r];
      hold_d[r]      = hold_q[r];
      if (grant[r]) begin
        rsp_valid_d[r] = 1'b1;
        live_d[r]      = 1'b1;
        bank_d[r]      = req_bank[r];
      end else if (rsp_valid_q[r] && rsp_ready[r]) begin
        rsp_valid_d[r] = 1'b0;
        live_d[r]      = 1'b0;
      end else if (rsp_valid_q[r] && live_q[r]) begin
        hold_d[r] = live_data[r];
        live_d[r] = 1'b0;
      end
    end
  end

  assign a_rsp_valid = rsp_valid_q[0];
  assign b_rsp_valid = rsp_valid_q[1];
  assign a_rsp_data  = rsp_data[0];
  assign b_rsp_data  = rsp_data[1];

  assign rr_d  = conflict ? a_grant : rr_q;
  assign cnt_d = (conflict && cnt_q != '1) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
  assign conflict_count = cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 2'b00;
      live_q      <= 2'b00;
      bank_q[0]   <= 2'd0;
      bank_q[1]   <= 2'd0;
      hold_q[0]   <= 32'h0;
      hold_q[1]   <= 32'h0;
    end else begin
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      live_q      <= live_d;
      bank_q[0]   <= bank_d[0];
      bank_q[1]   <= bank_d[1];
      hold_q[0]   <= hold_d[0];
      hold_q[1]   <= hold_d[1];
    end
  end

endmodule

// File: tb/tb_bank_scheduler.sv
// tb/tb_bank_scheduler.sv - scoreboard bench for bank_scheduler (round-robin and fixed-priority)
module tb_bank_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        a_req_valid = 0, b_req_valid = 0, a_rsp_ready = 0, b_rsp_ready = 0;
  logic [1:0]  a_req_bank = 0, b_req_bank = 0;
  logic [13:0] a_req_addr = 0, b_req_addr = 0;

  logic        r_a_req_ready, r_b_req_ready, r_a_rsp_valid, r_b_rsp_valid;
  logic [31:0] r_a_rsp_data, r_b_rsp_data;
  logic [13:0] r_pa [4];
  logic [31:0] r_din [4];
  logic [3:0]  r_cnt;

  logic        f_a_req_ready, f_b_req_ready, f_a_rsp_valid, f_b_rsp_valid;
  logic [31:0] f_a_rsp_data, f_b_rsp_data;
  logic [13:0] f_pa [4];
  logic [31:0] f_din [4];
  logic [15:0] f_cnt;

  bank_scheduler #(.ARB_MODE(0), .CNT_W(4)) u_rr (
    .clk(clk), .reset(reset),
    .a_req_valid(a_req_valid), .a_req_ready(r_a_req_ready), .a_req_bank(a_req_bank), .a_req_addr(a_req_addr),
    .a_rsp_valid(r_a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_data(r_a_rsp_data),
    .b_req_valid(b_req_valid), .b_req_ready(r_b_req_ready), .b_req_bank(b_req_bank), .b_req_addr(b_req_addr),
    .b_rsp_valid(r_b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_data(r_b_rsp_data),
    .port0_addr(r_pa[0]), .port1_addr(r_pa[1]), .port2_addr(r_pa[2]), .port3_addr(r_pa[3]),
    .port0_din(r_din[0]), .port1_din(r_din[1]), .port2_din(r_din[2]), .port3_din(r_din[3]),
    .conflict_count(r_cnt)
  );

  bank_scheduler #(.ARB_MODE(1), .CNT_W(16)) u_fp (
    .clk(clk), .reset(reset),
    .a_req_valid(a_req_valid), .a_req_ready(f_a_req_ready), .a_req_bank(a_req_bank), .a_req_addr(a_req_addr),
    .a_rsp_valid(f_a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_data(f_a_rsp_data),
    .b_req_valid(b_req_valid), .b_req_ready(f_b_req_ready), .b_req_bank(b_req_bank), .b_req_addr(b_req_addr),
    .b_rsp_valid(f_b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_data(f_b_rsp_data),
    .port0_addr(f_pa[0]), .port1_addr(f_pa[1]), .port2_addr(f_pa[2]), .port3_addr(f_pa[3]),
    .port0_din(f_din[0]), .port1_din(f_din[1]), .port2_din(f_din[2]), .port3_din(f_din[3]),
    .conflict_count(f_cnt)
  );

  function automatic logic [31:0] bank_word(input logic [1:0] n, input logic [13:0] a);
    return 32'hA500_0000 ^ ({30'h0, n} << 24) ^ ({18'h0, a} * 32'h0001_9E37);
  endfunction

  // Banks: synchronous read, data one cycle after the address is sampled.
  always @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      r_din[n] <= bank_word(n[1:0], r_pa[n]);
      f_din[n] <= bank_word(n[1:0], f_pa[n]);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard for the round-robin instance.
  logic [31:0] qa [$];
  logic [31:0] qb [$];
  logic        rr_m = 1'b0;
  int          cnt_m = 0;
  logic        sa, sb, ea, eb, conf, ga, gb;
  logic [13:0] exp_addr;

  always @(negedge clk) begin
    if (!reset) begin
      qa.delete();
      qb.delete();
      rr_m  = 1'b0;
      cnt_m = 0;
      check("rst_a_req_ready", r_a_req_ready, 0);
      check("rst_b_req_ready", r_b_req_ready, 0);
      check("rst_a_rsp_valid", r_a_rsp_valid, 0);
      check("rst_b_rsp_valid", r_b_rsp_valid, 0);
      for (int n = 0; n < 4; n++) check($sformatf("rst_port%0d_addr", n), r_pa[n], 0);
    end else begin
      sa   = (qa.size() != 0) && !a_rsp_ready;
      sb   = (qb.size() != 0) && !b_rsp_ready;
      ea   = a_req_valid && !sa;
      eb   = b_req_valid && !sb;
      conf = ea && eb && (a_req_bank == b_req_bank);
      ga   = ea && (!conf || !rr_m);
      gb   = eb && (!conf || rr_m);
      check("conflict_count", r_cnt, cnt_m);
      if (qa.size() != 0) begin
        check("a_rsp_valid", r_a_rsp_valid, 1);
        check("a_rsp_data", r_a_rsp_data, qa[0]);
        if (a_rsp_ready) void'(qa.pop_front());
      end else check("a_rsp_idle", r_a_rsp_valid, 0);
      if (qb.size() != 0) begin
        check("b_rsp_valid", r_b_rsp_valid, 1);
        check("b_rsp_data", r_b_rsp_data, qb[0]);
        if (b_rsp_ready) void'(qb.pop_front());
      end else check("b_rsp_idle", r_b_rsp_valid, 0);
      check("a_req_ready", r_a_req_ready, ga);
      check("b_req_ready", r_b_req_ready, gb);
      for (int n = 0; n < 4; n++) begin
        exp_addr = 14'h0;
        if (ga && a_req_bank == n[1:0]) exp_addr = a_req_addr;
        if (gb && b_req_bank == n[1:0]) exp_addr = b_req_addr;
        check($sformatf("port%0d_addr", n), r_pa[n], exp_addr);
      end
      if (ga) qa.push_back(bank_word(a_req_bank, a_req_addr));
      if (gb) qb.push_back(bank_word(b_req_bank, b_req_addr));
      if (conf) begin
        rr_m = ga;
        if (cnt_m < 15) cnt_m++;
      end
    end
  end

  task automatic set_in(input logic av, input logic [1:0] ab, input logic [13:0] aa, input logic ar,
                        input logic bv, input logic [1:0] bb, input logic [13:0] ba, input logic br);
    a_req_valid = av; a_req_bank = ab; a_req_addr = aa; a_rsp_ready = ar;
    b_req_valid = bv; b_req_bank = bb; b_req_addr = ba; b_rsp_ready = br;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    set_in(1, 1, 14'h5, 1, 1, 1, 14'h6, 1);
    repeat (3) step();
    check("rst_cnt", r_cnt, 0);
    check("rst_fp_a_req_ready", f_a_req_ready, 0);
    reset = 1'b1;

    // Different banks granted together, first cycle after reset release.
    set_in(1, 1, 14'h0010, 1, 1, 2, 14'h0020, 1);
    #1;
    check("diff_a_ready", r_a_req_ready, 1);
    check("diff_b_ready", r_b_req_ready, 1);
    step();
    set_in(0, 0, 0, 1, 0, 0, 0, 1);
    #1;
    check("diff_a_data", r_a_rsp_data, bank_word(2'd1, 14'h0010));
    check("diff_b_data", r_b_rsp_data, bank_word(2'd2, 14'h0020));
    check("diff_cnt", r_cnt, 0);
    step();

    // Four conflicts on bank 3: RR alternates A,B,A,B; fixed priority always A.
    reset = 1'b0; step(); reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(1, 3, 14'h100 + 14'(i), 1, 1, 3, 14'h200 + 14'(i), 1);
      #1;
      check("rr_a_ready", r_a_req_ready, (i % 2) == 0);
      check("rr_b_ready", r_b_req_ready, (i % 2) == 1);
      check("fp_a_ready", f_a_req_ready, 1);
      check("fp_b_ready", f_b_req_ready, 0);
      if (i > 0) check("fp_a_data", f_a_rsp_data, bank_word(2'd3, 14'h100 + 14'(i - 1)));
      step();
    end
    set_in(0, 0, 0, 1, 0, 0, 0, 1);
    #1;
    check("rr_cnt4", r_cnt, 4);
    check("fp_cnt4", f_cnt, 4);
    check("rr_last_b_valid", r_b_rsp_valid, 1);
    check("rr_last_b_data", r_b_rsp_data, bank_word(2'd3, 14'h203));
    step();

    // A stalls on bank 0 while B hammers the same bank.
    set_in(1, 0, 14'h0123, 1, 0, 0, 0, 1);
    #1;
    check("stall_hs_ready", r_a_req_ready, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 14'h0124, 0, 1, 0, 14'h40 + 14'(i * 5), 1);
      #1;
      check("stall_a_valid", r_a_rsp_valid, 1);
      check("stall_a_data", r_a_rsp_data, bank_word(2'd0, 14'h0123));
      check("stall_a_ready", r_a_req_ready, 0);
      check("stall_b_ready", r_b_req_ready, 1);
      step();
    end
    set_in(0, 0, 0, 1, 0, 0, 0, 1);
    #1;
    check("stall_accept_data", r_a_rsp_data, bank_word(2'd0, 14'h0123));
    step();
    check("stall_drop_valid", r_a_rsp_valid, 0);

    for (int i = 0; i < 300; i++) begin
      set_in($urandom_range(0, 1), 2'($urandom_range(0, 3)), 14'($urandom), $urandom_range(0, 3) != 0,
             $urandom_range(0, 1), 2'($urandom_range(0, 3)), 14'($urandom), $urandom_range(0, 3) != 0);
      step();
    end

    // Saturation of the 4-bit counter after 2^4+5 conflicts.
    set_in(0, 0, 0, 1, 0, 0, 0, 1);
    reset = 1'b0; step(); reset = 1'b1;
    for (int i = 0; i < 21; i++) begin
      set_in(1, 2, 14'(i), 1, 1, 2, 14'(i + 64), 1);
      step();
      if (i == 9) check("sat_cnt_mid", r_cnt, 10);
    end
    set_in(0, 0, 0, 1, 0, 0, 0, 1);
    #1;
    check("sat_cnt", r_cnt, 4'hF);
    check("fp_cnt21", f_cnt, 21);
    step();

    // Reset one cycle after an A handshake discards the response.
    set_in(1, 1, 14'h0055, 1, 0, 0, 0, 1);
    step();
    set_in(0, 0, 0, 1, 0, 0, 0, 1);
    check("rst_mid_pre_valid", r_a_rsp_valid, 1);
    reset = 1'b0;
    #1;
    check("rst_mid_async_valid", r_a_rsp_valid, 0);
    step(); step();
    reset = 1'b1;
    step();
    check("rst_mid_post_valid", r_a_rsp_valid, 0);
    set_in(1, 0, 14'h1, 1, 1, 0, 14'h2, 1);
    #1;
    check("post_rst_conf_a", r_a_req_ready, 1);
    check("post_rst_conf_b", r_b_req_ready, 0);
    step();
    set_in(0, 0, 0, 1, 0, 0, 0, 1);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bank_scheduler.md
BANK_SCHEDULER -- requirements
Module: bank_scheduler

Interface
REQ-001 SHALL have parameter ARB_MODE, default 0, meaning 0 = round-robin on bank conflict, 1 = fixed priority to requester A.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the saturating conflict counter.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-005 a_req_valid / b_req_valid  input  1  requester A/B read request valid.
REQ-006 a_req_ready / b_req_ready  output  1  request accepted this cycle.
REQ-007 a_req_bank / b_req_bank  input  2  target bank 0..3.
REQ-008 a_req_addr / b_req_addr  input  14  word address within bank.
REQ-009 a_rsp_valid / b_rsp_valid  output  1  read data valid.
REQ-010 a_rsp_ready / b_rsp_ready  input  1  requester accepts data.
REQ-011 a_rsp_data / b_rsp_data  output  32  read data.
REQ-012 port0_addr..port3_addr  output  14  bank addresses, sampled by the bank at the rising edge.
REQ-013 port0_din..port3_din  input  32  bank read data, valid one cycle after address sampled.
REQ-014 conflict_count  output  CNT_W  number of cycles in which both requesters were eligible for the same bank.

Function
REQ-015 Requester X SHALL be eligible when x_req_valid=1 and its response slot is not stalled (stalled = x_rsp_valid=1 and x_rsp_ready=0).
REQ-016 Eligible requesters targeting different banks SHALL both be granted in the same cycle.
REQ-017 Both eligible on the same bank (conflict): ARB_MODE=1 grants A; ARB_MODE=0 grants the requester not granted at the previous conflict.
REQ-018 Round-robin pointer SHALL update only in conflict cycles; it SHALL be unaffected by non-conflict grants.
REQ-019 x_req_ready SHALL equal grant for X, combinational from current-cycle inputs and state; handshake = x_req_valid & x_req_ready.
REQ-020 portN_addr SHALL carry the granted requester's address when bank N is granted; otherwise it SHALL be 14'h0000.
REQ-021 On an X handshake at edge N, x_rsp_valid SHALL be 1 in the cycle after edge N, with x_rsp_data = port<bank>_din of that cycle (latency exactly 1).
REQ-022 If x_rsp_ready=0 while x_rsp_valid=1, data SHALL be captured into a per-requester hold register; x_rsp_valid and x_rsp_data SHALL stay stable until accepted, independent of later bank traffic.
REQ-023 Response accepted (x_rsp_valid & x_rsp_ready) in the same cycle as a new X handshake SHALL yield back-to-back responses with no bubble (1 read/cycle/requester throughput).
REQ-024 x_rsp_valid SHALL drop the cycle after acceptance when no new X handshake occurred.
REQ-025 Only one outstanding response per requester; a stalled requester SHALL not be granted and SHALL not block the other requester, including on the same bank.
REQ-026 conflict_count SHALL increment by 1 per conflict cycle and saturate at all-ones.
REQ-027 x_req_bank/x_req_addr SHALL be ignored while x_req_valid=0.

Reset
REQ-028 Reset asserted SHALL asynchronously force a_rsp_valid=0, b_rsp_valid=0, hold registers=0, conflict_count=0, round-robin pointer so the next conflict grants A.
REQ-029 While reset is low, a_req_ready=b_req_ready=0 and all portN_addr=0.
REQ-030 Reset mid-transaction SHALL discard any pending response; no response SHALL appear after reset release for pre-reset requests.
REQ-031 First grant SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-032 A reads bank 1 addr 0x0010, B reads bank 2 addr 0x0020, both rsp_ready=1 -> both req_ready=1 same cycle; next cycle a_rsp_data=port1_din, b_rsp_data=port2_din, conflict_count=0.
REQ-033 ARB_MODE=0, A and B both bank 3 for 4 consecutive cycles -> grants A,B,A,B; conflict_count=4; each response one cycle after its grant.
REQ-034 ARB_MODE=1, same stimulus -> A granted all 4 cycles, b_req_ready=0 throughout.
REQ-035 A handshake to bank 0, a_rsp_ready=0 for 3 cycles while B hammers bank 0 with changing addresses -> a_rsp_data stable at original value, a_req_ready=0, B granted every cycle; after a_rsp_ready=1, a_rsp_valid drops next cycle.
REQ-036 Force 2^CNT_W+5 conflict cycles -> conflict_count holds at all-ones.
REQ-037 Assert reset one cycle after an A handshake -> a_rsp_valid=0 immediately and stays 0 after release; next conflict grants A.
